muldiv_unit: RTL and testbench

//  Iterative MULT/MULTU/DIV/DIVU engine in the EX stage, beside the ALU; produces the 64-bit {hi,lo} result for the HI/LO registers.

---
 rtl/muldiv_unit.sv | 118 +++++++++++
 tb/tb_muldiv_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine producing {hi,lo}; optional FAST_MULT_EN single-cycle multiply
//   clk, rst (async, active-high)
//   start_i, op_i[1:0] (00 MULT, 01 MULTU, 10 DIV, 11 DIVU), a_i, b_i, flush_i
//   stall_o (combinational hold), done_o (one-cycle pulse), hi_o, lo_o (registered results)
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mul_acc, div_acc;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d, a_mag, b_mag, rem_sub;
  logic neg_q, neg_d, rneg_q, rneg_d, done_q, done_d;
  logic idle_like, accept, last, sa, sb, ge, mul_fin;
  assign idle_like = state_q == IDLE || state_q == DONE;
  assign accept    = idle_like & start_i & !flush_i;
  assign stall_o   = accept | (!flush_i & !idle_like);
  assign done_o    = done_q;
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;
  assign sa        = !op_i[0] & a_i[WIDTH-1];
  assign sb        = !op_i[0] & b_i[WIDTH-1];
  assign a_mag     = sa ? -a_i : a_i;
  assign b_mag     = sb ? -b_i : b_i;
  assign last      = cnt_q == CW'(WIDTH - 1);
`ifdef FAST_MULT_EN
  assign mul_acc = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
  assign mul_fin = 1'b1;
`else
  // acc = {partial product, remaining multiplier bits}; add on lsb, then shift right
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign mul_acc = {mul_sum, acc_q[WIDTH-1:1]};
  assign mul_fin = last;
`endif
  // acc = {remainder, dividend bits / quotient bits}; trial-subtract the shifted remainder
  assign ge      = acc_q[2*WIDTH-1:WIDTH-1] >= {1'b0, b_q};
  assign rem_sub = acc_q[2*WIDTH-2:WIDTH-1] - b_q;
  assign div_acc = {ge ? rem_sub : acc_q[2*WIDTH-2:WIDTH-1], acc_q[WIDTH-2:0], ge};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    if (flush_i) state_d = IDLE;
    else if (accept) begin
      state_d = op_i[1] ? DIV : MUL;
      cnt_d   = '0;
      a_d     = a_mag;
      b_d     = b_mag;
      acc_d   = {{WIDTH{1'b0}}, op_i[1] ? a_mag : b_mag};
      // divide by zero leaves the all-ones quotient un-negated
      neg_d   = (sa ^ sb) & (!op_i[1] | (|b_i));
      rneg_d  = sa;
    end else if (state_q == MUL) begin
      acc_d = mul_acc;
      cnt_d = cnt_q + CW'(1);
      if (mul_fin) begin
        state_d      = DONE;
        done_d       = 1'b1;
        {hi_d, lo_d} = neg_q ? -mul_acc : mul_acc;
      end
    end else if (state_q == DIV) begin
      acc_d = div_acc;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        state_d = DONE;
        done_d  = 1'b1;
        hi_d    = rneg_q ? -div_acc[2*WIDTH-1:WIDTH] : div_acc[2*WIDTH-1:WIDTH];
        lo_d    = neg_q ? -div_acc[WIDTH-1:0] : div_acc[WIDTH-1:0];
      end
    end else state_d = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit
module tb_muldiv_unit;
`ifdef FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 32;
`endif
  logic clk = 1'b0, rst = 1'b1, start_i = 1'b0, flush_i = 1'b0, stall_o, done_o;
  logic [1:0] op_i = 2'b00;
  logic [31:0] a_i = '0, b_i = '0, hi_o, lo_o;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .flush_i(flush_i), .stall_o(stall_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sv;
    logic [63:0] q, r;
    sa = {{32{a[31]}}, a};
    sv = {{32{b[31]}}, b};
    if (op == 2'b00) return sa * sv;
    if (op == 2'b01) return {32'd0, a} * {32'd0, b};
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (op == 2'b10) begin
      q = sa / sv;
      r = sa % sv;
    end else begin
      q = {32'd0, a / b};
      r = {32'd0, a % b};
    end
    return {r[31:0], q[31:0]};
  endfunction
  // monitor: every done_o pulse must match the oldest expectation, including its cycle
  always @(negedge clk) begin
    if (!rst && done_o) begin
      if (sb.size() == 0) chk("spurious_done", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("hi", {32'd0, hi_o}, {32'd0, e.res[63:32]});
        chk("lo", {32'd0, lo_o}, {32'd0, e.res[31:0]});
        chk("done_cyc", 64'(cyc), 64'(e.cyc));
      end
    end
  end
  // call just after a negedge; returns the accept edge number
  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input bit push, output int n);
    exp_t e;
    op_i = op;
    a_i = a;
    b_i = b;
    start_i = 1'b1;
    #1 chk("stall_req", {63'd0, stall_o}, 64'd1);
    @(posedge clk);
    #1 n = cyc;
    start_i = 1'b0;
    if (push) begin
      e.res = exp;
      e.cyc = n + (op[1] ? 32 : MUL_LAT);
      sb.push_back(e);
    end
  endtask
  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      chk("timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    int n;
    @(negedge clk);
    drive(op, a, b, exp, 1'b1, n);
    drain();
  endtask
  initial begin
    int n, bad, t;
    logic [1:0] op;
    logic [31:0] a, b;
    repeat (2) @(negedge clk);
    chk("rst_hi", {32'd0, hi_o}, 64'd0);
    chk("rst_lo", {32'd0, lo_o}, 64'd0);
    chk("rst_done", {63'd0, done_o}, 64'd0);
    chk("rst_stall", {63'd0, stall_o}, 64'd0);
    rst = 1'b0;
    // T1 with stall profile
    @(negedge clk);
    drive(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1, n);
    bad = 0;
    while (cyc < n + MUL_LAT + 1 && cyc < n + 40) begin
      @(negedge clk);
      if ((cyc <= n + MUL_LAT - 1 && !stall_o) || (cyc == n + MUL_LAT && stall_o)) bad++;
    end
    chk("t1_stall", 64'(bad), 64'd0);
    drain();
    // T2..T4 directed vectors
    issue(2'b00, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
    issue(2'b11, 32'd7, 32'd2, {32'd1, 32'd3});
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
    issue(2'b11, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF});
    issue(2'b10, 32'hFFFF_FFF0, 32'd0, {32'hFFFF_FFF0, 32'hFFFF_FFFF});
    // T5 flush at N+10 of a DIV, then a fresh start at N+11
    @(negedge clk);
    drive(2'b10, 32'd100, 32'd7, 64'd0, 1'b0, n);
    while (cyc < n + 9) @(negedge clk);
    flush_i = 1'b1;
    #1 chk("flush_stall", {63'd0, stall_o}, 64'd0);
    @(posedge clk);
    #1 flush_i = 1'b0;
    @(negedge clk);
    chk("flush_hi", {32'd0, hi_o}, 64'hFFFF_FFF0);
    chk("flush_lo", {32'd0, lo_o}, 64'hFFFF_FFFF);
    drive(2'b11, 32'd100, 32'd7, model(2'b11, 32'd100, 32'd7), 1'b1, n);
    drain();
    // T6 reset mid-MULT
    @(negedge clk);
    drive(2'b00, 32'd12345, 32'd678, 64'd0, 1'b0, n);
    while (cyc < n + 4) @(negedge clk);
    rst = 1'b1;
    #1 chk("mid_rst_hi", {32'd0, hi_o}, 64'd0);
    chk("mid_rst_lo", {32'd0, lo_o}, 64'd0);
    chk("mid_rst_stall", {63'd0, stall_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    // back-to-back: second start presented in the DONE cycle
    @(negedge clk);
    drive(2'b01, 32'd300, 32'd400, model(2'b01, 32'd300, 32'd400), 1'b1, n);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!done_o && t < 40);
    drive(2'b10, 32'hFFFF_FC00, 32'd9, model(2'b10, 32'hFFFF_FC00, 32'd9), 1'b1, n);
    drain();
    // random mix
    for (int i = 0; i < 10; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = (i % 5 == 4) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      issue(op, a, b, model(op, a, b));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
